// File: rtl/obb_pair_scheduler_pkg.sv
// Shared physics types: OBB/contact/impulse records and the pair-scheduler state set.
package obb_pair_scheduler_pkg;

    localparam int MAX_BODIES = 16;
    localparam int BODY_IDX_W = $clog2(MAX_BODIES);
    localparam int COORD_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_COMMIT
    } sched_state_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] cx;
        logic signed [COORD_W-1:0] cy;
        logic        [COORD_W-1:0] hx;
        logic        [COORD_W-1:0] hy;
        logic        [COORD_W-1:0] angle;
    } obb_t;

    typedef struct packed {
        logic        [BODY_IDX_W-1:0] body_a;
        logic        [BODY_IDX_W-1:0] body_b;
        logic signed [COORD_W-1:0]    nx;
        logic signed [COORD_W-1:0]    ny;
        logic        [COORD_W-1:0]    depth;
    } contact_t;

    typedef struct packed {
        logic        [BODY_IDX_W-1:0] body;
        logic signed [COORD_W-1:0]    jx;
        logic signed [COORD_W-1:0]    jy;
    } impulse_t;

    function automatic int num_pairs(input int n);
        return n * (n - 1) / 2;
    endfunction

endpackage

// File: rtl/obb_pair_scheduler_cursor.sv
// Lexicographic (a, b) pair cursor with a < b; holds on the final pair.
module pair_cursor #(
    parameter  int N_BODIES = 4,
    localparam int IDX_W    = $clog2(N_BODIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [IDX_W-1:0] a,
    output logic [IDX_W-1:0] b,
    output logic             last
);

    localparam logic [IDX_W-1:0] LAST_A = IDX_W'(N_BODIES - 2);
    localparam logic [IDX_W-1:0] LAST_B = IDX_W'(N_BODIES - 1);

    logic [IDX_W-1:0] a_reg, a_next;
    logic [IDX_W-1:0] b_reg, b_next;

    assign a    = a_reg;
    assign b    = b_reg;
    assign last = (a_reg == LAST_A) && (b_reg == LAST_B);

    always_comb begin
        a_next = a_reg;
        b_next = b_reg;
        if (clear) begin
            a_next = '0;
            b_next = IDX_W'(1);
        end else if (advance && !last) begin
            // End of a row: next row starts right above the diagonal.
            if (b_reg == LAST_B) begin
                a_next = a_reg + IDX_W'(1);
                b_next = a_reg + IDX_W'(2);
            end else begin
                b_next = b_reg + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            a_reg <= a_next;
            b_reg <= b_next;
        end
    end

endmodule

// File: rtl/obb_pair_scheduler.sv
// Sequences every body pair through the shared detector/resolver pipeline once per
// frame, gathers per-body hit flags and strobes commit when all results are back.
module obb_pair_scheduler
    import obb_pair_scheduler_pkg::*;
#(
    parameter  int N_BODIES        = 4,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int IDX_W           = $clog2(N_BODIES),
    localparam int NPAIRS          = num_pairs(N_BODIES),
    localparam int CNT_W           = $clog2(NPAIRS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    output logic                pair_valid,
    input  logic                pair_ready,
    output logic [IDX_W-1:0]    pair_a,
    output logic [IDX_W-1:0]    pair_b,
    input  logic                res_valid,
    input  logic                res_hit,
    input  logic                res_ignore,
    input  logic [IDX_W-1:0]    res_a,
    input  logic [IDX_W-1:0]    res_b,
    output logic [N_BODIES-1:0] body_hit,
    output logic [CNT_W-1:0]    hit_count,
    output logic                commit,
    output logic                busy,
    output logic                overrun
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    sched_state_t        state_reg, state_next;
    logic [OUT_W-1:0]    outstanding_reg, outstanding_next;
    logic [N_BODIES-1:0] body_hit_reg, body_hit_next;
    logic [CNT_W-1:0]    hit_count_reg, hit_count_next;
    logic                overrun_reg, overrun_next;

    logic handshake;
    logic res_accept;
    logic hit_accept;
    logic frame_accept;
    logic cursor_last;

    assign pair_valid   = (state_reg == ST_ISSUE) && (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
    assign handshake    = pair_valid && pair_ready;
    // Results with nothing in flight are stale (e.g. after a mid-frame reset).
    assign res_accept   = res_valid && (outstanding_reg != '0);
    assign hit_accept   = res_accept && res_hit && !res_ignore;
    assign frame_accept = frame_start && (state_reg == ST_IDLE);

    assign busy      = (state_reg != ST_IDLE);
    assign commit    = (state_reg == ST_COMMIT);
    assign body_hit  = body_hit_reg;
    assign hit_count = hit_count_reg;
    assign overrun   = overrun_reg;

    pair_cursor #(
        .N_BODIES(N_BODIES)
    ) u_cursor (
        .clk    (clk),
        .reset  (reset),
        .clear  (frame_accept),
        .advance(handshake),
        .a      (pair_a),
        .b      (pair_b),
        .last   (cursor_last)
    );

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({handshake, res_accept})
            2'b10:   outstanding_next = outstanding_reg + OUT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - OUT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (frame_start) state_next = ST_ISSUE;
            ST_ISSUE:  if (handshake && cursor_last) state_next = ST_DRAIN;
            // Looking at the next count lets the final result's own cycle trigger commit.
            ST_DRAIN:  if (outstanding_next == '0) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < N_BODIES; gi++) begin : g_body_hit
        assign body_hit_next[gi] = frame_accept ? 1'b0 :
            body_hit_reg[gi] | (hit_accept && ((res_a == IDX_W'(gi)) || (res_b == IDX_W'(gi))));
    end

    always_comb begin
        hit_count_next = hit_count_reg;
        if (frame_accept) begin
            hit_count_next = '0;
        end else if (hit_accept && (hit_count_reg != CNT_W'(NPAIRS))) begin
            hit_count_next = hit_count_reg + CNT_W'(1);
        end
    end

    assign overrun_next = overrun_reg || (frame_start && busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            outstanding_reg <= '0;
            body_hit_reg    <= '0;
            hit_count_reg   <= '0;
            overrun_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            body_hit_reg    <= body_hit_next;
            hit_count_reg   <= hit_count_next;
            overrun_reg     <= overrun_next;
        end
    end

endmodule

// File: tb/tb_obb_pair_scheduler.sv
// Self-checking bench for obb_pair_scheduler: frame table, corner sequences, random frames.
module tb_obb_pair_scheduler;

    localparam int N     = 4;
    localparam int MO    = 2;
    localparam int IDX_W = $clog2(N);
    localparam int NP    = N * (N - 1) / 2;
    localparam int CNT_W = $clog2(NP + 1);

    logic             clk = 1'b0;
    logic             reset, frame_start, pair_ready;
    logic             res_valid, res_hit, res_ignore;
    logic [IDX_W-1:0] res_a, res_b;
    logic             pair_valid, commit, busy, overrun;
    logic [IDX_W-1:0] pair_a, pair_b;
    logic [N-1:0]     body_hit;
    logic [CNT_W-1:0] hit_count;

    always #5 clk = ~clk;

    obb_pair_scheduler #(.N_BODIES(N), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_a(pair_a), .pair_b(pair_b),
        .res_valid(res_valid), .res_hit(res_hit), .res_ignore(res_ignore),
        .res_a(res_a), .res_b(res_b),
        .body_hit(body_hit), .hit_count(hit_count),
        .commit(commit), .busy(busy), .overrun(overrun)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Emulated detector/resolver pipeline: in-order results after a delay.
    typedef struct { int a; int b; bit hit; bit ign; int due; } pipe_t;
    pipe_t pipe_q[$];
    bit    cfg_hit[N][N];
    bit    cfg_ign[N][N];
    int    cfg_delay      = 1;
    bit    cfg_rand_delay = 0;
    int    last_due       = 0;
    int    ready_mode     = 0;
    int    stall_left     = 0;
    bit    stray          = 0;

    // Reference model: frame progress in terms of the pair list and in-flight count.
    int           pairs_a[$];
    int           pairs_b[$];
    bit           m_issuing, m_draining, m_committing, m_overrun;
    int           m_next, m_infl, m_count;
    logic [N-1:0] m_hits;

    logic         s_commit, s_hs;
    logic [N-1:0] s_body;
    int           s_count;

    typedef struct {
        logic [NP-1:0] hits;
        logic [NP-1:0] ign;
        int            delay;
        int            rmode;
        logic [N-1:0]  exp_body;
        int            exp_count;
        int            exp_lat;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_issuing = 0; m_draining = 0; m_committing = 0; m_overrun = 0;
        m_next = 0; m_infl = 0; m_count = 0; m_hits = '0;
    endtask

    task automatic step(input logic fs, input logic rst);
        pipe_t ent;
        int    d;
        logic  exp_pv, hs, racc, was_busy;
        reset       = rst;
        frame_start = fs;
        pair_ready  = 1'b1;
        if (ready_mode == 1) begin
            if (pair_valid && pair_a == IDX_W'(1) && pair_b == IDX_W'(2) && stall_left > 0) begin
                pair_ready = 1'b0;
                stall_left--;
            end
        end else if (ready_mode == 2) begin
            pair_ready = 1'($urandom_range(0, 1));
        end
        res_valid = 0; res_hit = 0; res_ignore = 0; res_a = '0; res_b = '0;
        if (pipe_q.size() > 0 && pipe_q[0].due <= cyc) begin
            ent = pipe_q.pop_front();
            res_valid = 1; res_hit = ent.hit; res_ignore = ent.ign;
            res_a = IDX_W'(ent.a); res_b = IDX_W'(ent.b);
        end else if (stray) begin
            res_valid = 1; res_hit = 1; res_a = IDX_W'(0); res_b = IDX_W'(3);
        end

        @(negedge clk);
        exp_pv = m_issuing && (m_infl < MO);
        check("pair_valid", pair_valid, exp_pv);
        if (exp_pv) begin
            check("pair_a", pair_a, pairs_a[m_next]);
            check("pair_b", pair_b, pairs_b[m_next]);
        end
        check("busy", busy, m_issuing || m_draining || m_committing);
        check("commit", commit, m_committing);
        check("body_hit", body_hit, m_hits);
        check("hit_count", hit_count, m_count);
        check("overrun", overrun, m_overrun);
        s_commit = commit; s_body = body_hit; s_count = int'(hit_count);
        s_hs = pair_valid && pair_ready;

        if (pair_valid && pair_ready) begin
            d = cfg_rand_delay ? int'($urandom_range(1, 6)) : cfg_delay;
            ent.a = int'(pair_a); ent.b = int'(pair_b);
            ent.hit = cfg_hit[ent.a][ent.b]; ent.ign = cfg_ign[ent.a][ent.b];
            ent.due = (cyc + d <= last_due) ? last_due + 1 : cyc + d;
            last_due = ent.due;
            pipe_q.push_back(ent);
        end

        hs   = exp_pv && pair_ready;
        racc = res_valid && (m_infl > 0);
        if (rst) begin
            model_reset();
        end else begin
            was_busy = m_issuing || m_draining || m_committing;
            if (racc && res_hit && !res_ignore) begin
                m_hits[res_a] = 1'b1;
                m_hits[res_b] = 1'b1;
                if (m_count < NP) m_count++;
            end
            m_infl = m_infl + (hs ? 1 : 0) - (racc ? 1 : 0);
            if (m_committing) begin
                m_committing = 0;
            end else if (m_draining && m_infl == 0) begin
                m_draining = 0; m_committing = 1;
            end else if (m_issuing && hs) begin
                m_next++;
                if (m_next == NP) begin m_issuing = 0; m_draining = 1; end
            end
            if (fs) begin
                if (was_busy) m_overrun = 1;
                else begin m_issuing = 1; m_next = 0; m_hits = '0; m_count = 0; end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_frame(input bit fs_drain, input bit fs_commit, input bit rand_fs, output int lat);
        bit done;
        int n;
        bit fs;
        done = 0;
        lat  = -1;
        step(1'b1, 1'b0);
        n = 1;
        while (!done && n < 300) begin
            fs = 0;
            if (fs_drain && m_draining) begin fs = 1; fs_drain = 0; end
            if (fs_commit && m_committing) begin fs = 1; fs_commit = 0; end
            if (rand_fs && $urandom_range(0, 15) == 0) fs = 1;
            step(fs, 1'b0);
            n++;
            if (s_commit) begin done = 1; lat = n; end
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL frame_timeout: got no commit within %0d cycles expected commit", n);
        end
    endtask

    task automatic set_cfg(input logic [NP-1:0] hits, input logic [NP-1:0] ign);
        for (int k = 0; k < NP; k++) begin
            cfg_hit[pairs_a[k]][pairs_b[k]] = hits[k];
            cfg_ign[pairs_a[k]][pairs_b[k]] = ign[k];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int hs_seen;
        for (int a = 0; a < N; a++)
            for (int b = a + 1; b < N; b++) begin
                pairs_a.push_back(a);
                pairs_b.push_back(b);
            end
        model_reset();

        reset = 1; frame_start = 0; pair_ready = 1;
        res_valid = 0; res_hit = 0; res_ignore = 0; res_a = '0; res_b = '0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b1);
        check("rst_pair_valid", pair_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_commit", commit, 0);
        check("rst_overrun", overrun, 0);
        check("rst_body_hit", body_hit, 0);
        check("rst_hit_count", hit_count, 0);

        // pair order: (0,1)(0,2)(0,3)(1,2)(1,3)(2,3)
        vecs[0] = '{6'b000000, 6'b000000, 1, 0, 4'b0000, 0, 9};
        vecs[1] = '{6'b001010, 6'b001000, 1, 0, 4'b0101, 1, 9};
        vecs[2] = '{6'b111111, 6'b000000, 1, 0, 4'b1111, 6, 9};
        vecs[3] = '{6'b100000, 6'b000000, 1, 0, 4'b1100, 1, 9};
        vecs[4] = '{6'b010001, 6'b000001, 1, 0, 4'b1010, 1, 9};
        vecs[5] = '{6'b111111, 6'b111111, 5, 0, 4'b0000, 0, 21};
        vecs[6] = '{6'b000110, 6'b000000, 1, 1, 4'b1101, 2, 12};

        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].hits, vecs[i].ign);
            cfg_delay = vecs[i].delay; cfg_rand_delay = 0;
            ready_mode = vecs[i].rmode; stall_left = 3;
            run_frame(0, 0, 0, lat);
            check("vec_body_hit", s_body, vecs[i].exp_body);
            check("vec_hit_count", s_count, vecs[i].exp_count);
            check("vec_latency", lat, vecs[i].exp_lat);
            $display("vec %0d: latency=%0d body_hit=%b hit_count=%0d", i, lat, s_body, s_count);
            step(1'b0, 1'b0);
        end
        ready_mode = 0;

        // frame_start during DRAIN and during COMMIT
        set_cfg(6'b000001, 6'b000000);
        cfg_delay = 3;
        run_frame(1, 1, 0, lat);
        check("ovr_latency", lat, 15);
        check("ovr_body_hit", s_body, 4'b0011);
        step(1'b0, 1'b0);
        check("ovr_flag", overrun, 1);
        $display("overrun frame: latency=%0d body_hit=%b overrun=%b", lat, s_body, overrun);

        // stray results while idle
        stray = 1;
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        stray = 0;
        check("stray_body_hit", body_hit, 4'b0011);
        check("stray_hit_count", hit_count, 1);
        $display("stray results: body_hit=%b hit_count=%0d", body_hit, hit_count);

        // reset in ISSUE after two handshakes; late results must be ignored
        set_cfg(6'b111111, 6'b000000);
        cfg_delay = 2;
        hs_seen = 0;
        step(1'b1, 1'b0);
        for (int k = 0; k < 20 && hs_seen < 2; k++) begin
            step(1'b0, 1'b0);
            if (s_hs) hs_seen++;
        end
        step(1'b0, 1'b1);
        check("mrst_pair_valid", pair_valid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_commit", commit, 0);
        check("mrst_overrun", overrun, 0);
        check("mrst_body_hit", body_hit, 0);
        check("mrst_hit_count", hit_count, 0);
        for (int k = 0; k < 10 && pipe_q.size() > 0; k++) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        cfg_delay = 1;
        run_frame(0, 0, 0, lat);
        check("post_rst_latency", lat, 9);
        check("post_rst_body_hit", s_body, 4'b1111);
        check("post_rst_hit_count", s_count, 6);
        $display("after mid-frame reset: latency=%0d body_hit=%b hit_count=%0d", lat, s_body, s_count);

        // random frames against the model
        ready_mode = 2; cfg_rand_delay = 1;
        for (int f = 0; f < 25; f++) begin
            set_cfg(NP'($urandom), NP'($urandom) & NP'($urandom));
            run_frame(0, 0, 1, lat);
            $display("random frame %0d: latency=%0d body_hit=%b hit_count=%0d", f, lat, s_body, s_count);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                stray = 1'($urandom_range(0, 1));
                step(1'b0, 1'b0);
            end
            stray = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
